debounce_sync: RTL

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_sync_if.sv | 30 +++
 rtl/debounce_sync.sv | 134 +++++++++++++
 2 files changed

// File: rtl/debounce_sync_if.sv
// Debouncer signal bundle: raw input and sample tick in, debounced level,
// edge pulses and qualification status out.
interface debounce_sync_if;
   logic din;
   logic en;
   logic q;
   logic rise;
   logic fall;
   logic busy;

   // Producer of the raw input (the bench or the surrounding logic)
   modport master (
      output din,
      output en,
      input  q,
      input  rise,
      input  fall,
      input  busy
   );

   // The debouncer itself
   modport slave (
      input  din,
      input  en,
      output q,
      output rise,
      output fall,
      output busy
   );
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a four-state qualification FSM.
// A new input level must be seen for STABLE_CNT enabled cycles before the
// debounced output q follows; rise/fall pulse for one cycle with the change.
// Any reversal of the synchronized level during qualification aborts it,
// whether or not the sample tick is high.
module debounce_sync #(
   parameter int CNT_W      = 16,
   parameter int STABLE_CNT = 50000
) (
   input  logic            clk,
   input  logic            rst,
   debounce_sync_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      CHK_HI  = 2'd1,
      IDLE_HI = 2'd2,
      CHK_LO  = 2'd3
   } state_t;

   // Last counter value of a qualification window; fits CNT_W since
   // STABLE_CNT never exceeds 2**CNT_W, so the counter never wraps.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic             s1_reg;
   logic             s2_reg;
   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             q_reg;
   logic             q_next;
   logic             rise_reg;
   logic             rise_next;
   logic             fall_reg;
   logic             fall_next;
   logic             busy_reg;
   logic             busy_next;

   // Synchronize the raw input every cycle, independent of the sample tick
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
      end else begin
         s1_reg <= bus.din;
         s2_reg <= s1_reg;
      end
   end

   // FSM state, counter and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE_LO;
         cnt_reg   <= '0;
         q_reg     <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         q_reg     <= q_next;
         rise_reg  <= rise_next;
         fall_reg  <= fall_next;
         busy_reg  <= busy_next;
      end
   end

   // Next-state, counter and output decode; level reversal checked before en
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      q_next     = q_reg;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      case (state_reg)
         IDLE_LO: begin
            if (s2_reg) begin
               state_next = CHK_HI;
               cnt_next   = '0;
            end
         end
         CHK_HI: begin
            if (!s2_reg) begin
               state_next = IDLE_LO;
               cnt_next   = '0;
            end else if (bus.en) begin
               if (cnt_reg == CNT_LAST) begin
                  state_next = IDLE_HI;
                  cnt_next   = '0;
                  q_next     = 1'b1;
                  rise_next  = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         IDLE_HI: begin
            if (!s2_reg) begin
               state_next = CHK_LO;
               cnt_next   = '0;
            end
         end
         CHK_LO: begin
            if (s2_reg) begin
               state_next = IDLE_HI;
               cnt_next   = '0;
            end else if (bus.en) begin
               if (cnt_reg == CNT_LAST) begin
                  state_next = IDLE_LO;
                  cnt_next   = '0;
                  q_next     = 1'b0;
                  fall_next  = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         default: begin
            state_next = IDLE_LO;
            cnt_next   = '0;
         end
      endcase
      busy_next = (state_next == CHK_HI) || (state_next == CHK_LO);
   end

   assign bus.q    = q_reg;
   assign bus.rise = rise_reg;
   assign bus.fall = fall_reg;
   assign bus.busy = busy_reg;

endmodule
